// File: rtl/clock_pkg.sv
// Shared encodings and defaults for the minutes/hours stage of the digital clock.
package clock_pkg;

  localparam int BCD_W        = 4;
  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_MIN  = 2'b01,
    ST_SET_HOUR = 2'b10
  } state_t;

  // The state encoding doubles as the blink-field code shown to the display.
  function automatic logic [1:0] field_of(state_t s);
    return logic'(s == ST_SET_HOUR) ? 2'b10 :
           logic'(s == ST_SET_MIN)  ? 2'b01 : 2'b00;
  endfunction

endpackage

// File: rtl/bcd2_wrap_counter.sv
// Two-digit BCD counter 00..MAX; increments on inc and wraps to 00 after MAX.
module bcd2_wrap_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       inc,
  output logic [7:0] out,
  output logic       wrap
);

  localparam logic [BCD_W-1:0] TENS_MAX  = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] UNITS_MAX = BCD_W'(MAX % 10);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_units;

  assign out  = {r_tens, r_units};
  assign wrap = inc && (r_tens == TENS_MAX) && (r_units == UNITS_MAX);

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (inc) begin
      if (wrap) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units == BCD_W'(9)) begin
        r_tens  <= r_tens + BCD_W'(1);
        r_units <= '0;
      end else begin
        r_units <= r_units + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/count_min_hour.sv
// Minutes/hours stage: counts minute carries, supports button time-set, flags day rollover.
module count_min_hour
  import clock_pkg::*;
#(
  parameter int MIN_MAX  = MIN_MAX_DEF,
  parameter int HOUR_MAX = HOUR_MAX_DEF
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       EN,
  input  logic       Min_Pulse,
  input  logic       Set_Mode,
  input  logic       Set_Sel,
  input  logic       Set_Inc,
  output logic [7:0] Minutes,
  output logic [7:0] Hours,
  output logic       Day_Pulse,
  output logic [1:0] Set_Field
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_min_q;
  logic       r_sel_q;
  logic       r_inc_q;
  logic       r_day;
  logic [1:0] r_field;

  logic w_ev_min;
  logic w_ev_sel;
  logic w_ev_inc;
  logic w_min_inc;
  logic w_hour_inc;
  logic w_min_wrap;
  logic w_hour_wrap;
  logic w_day;

  // History regs reset high so a level held through reset release is not an edge.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_min_q <= 1'b1;
      r_sel_q <= 1'b1;
      r_inc_q <= 1'b1;
    end else begin
      r_min_q <= Min_Pulse;
      r_sel_q <= Set_Sel;
      r_inc_q <= Set_Inc;
    end
  end

  assign w_ev_min = Min_Pulse & ~r_min_q;
  assign w_ev_sel = Set_Sel   & ~r_sel_q;
  assign w_ev_inc = Set_Inc   & ~r_inc_q;

  // Increments come from the current state; the carry chain only runs in RUN.
  assign w_min_inc  = EN && (((r_state == ST_RUN) && w_ev_min) ||
                             ((r_state == ST_SET_MIN) && w_ev_inc));
  assign w_hour_inc = EN && (((r_state == ST_RUN) && w_min_wrap) ||
                             ((r_state == ST_SET_HOUR) && w_ev_inc));
  assign w_day      = (r_state == ST_RUN) && w_hour_wrap;

  always_comb begin
    w_next_state = r_state;
    if (EN) begin
      case (r_state)
        ST_RUN: begin
          if (Set_Mode) w_next_state = ST_SET_MIN;
        end
        ST_SET_MIN: begin
          if (!Set_Mode)     w_next_state = ST_RUN;
          else if (w_ev_sel) w_next_state = ST_SET_HOUR;
        end
        ST_SET_HOUR: begin
          if (!Set_Mode)     w_next_state = ST_RUN;
          else if (w_ev_sel) w_next_state = ST_SET_MIN;
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_RUN;
      r_field <= 2'b00;
      r_day   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_field <= field_of(w_next_state);
      r_day   <= w_day;
    end
  end

  bcd2_wrap_counter #(.MAX(MIN_MAX)) u_min (
    .Clk  (Clk),
    .RST  (RST),
    .inc  (w_min_inc),
    .out  (Minutes),
    .wrap (w_min_wrap)
  );

  bcd2_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
    .Clk  (Clk),
    .RST  (RST),
    .inc  (w_hour_inc),
    .out  (Hours),
    .wrap (w_hour_wrap)
  );

  assign Day_Pulse = r_day;
  assign Set_Field = r_field;

endmodule
